cla_addsub_pipe: RTL

//  Parametrised, pipelined carry-lookahead add/subtract unit with full flag generation (N,Z,C,V).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/cla_chunk.sv | 55 +++++
 rtl/cla_addsub_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings for the add/subtract unit and
// the bit positions used when the ALU packs N/Z/C/V into a flag word.
package alu_pkg;

    // Two-bit add/subtract operation select.
    // Bit 0 inverts b. Bit 1 selects the external carry in.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,  // a + b
        OP_SUB = 2'b01,  // a - b
        OP_ADC = 2'b10,  // a + b + ci
        OP_SBC = 2'b11   // a - b - ~ci
    } alu_op_e;

    // Flag word bit positions shared with the ALU writeback stage.
    localparam int unsigned FLAG_V     = 0;
    localparam int unsigned FLAG_C     = 1;
    localparam int unsigned FLAG_Z     = 2;
    localparam int unsigned FLAG_N     = 3;
    localparam int unsigned FLAG_WIDTH = 4;

endpackage

// File: rtl/cla_chunk.sv
// Combinational carry-lookahead adder for one CW-bit chunk.
// Each carry is a flat sum of generate/propagate products, so no carry
// ripples through the chunk.
//   a_i, b_i  : chunk operands (b already inverted for subtraction)
//   ci_i      : carry into bit 0 of the chunk
//   sum_o     : chunk sum
//   co_o      : carry out of the chunk MSB
//   cmsb_o    : carry into the chunk MSB (used for signed overflow)
//   zero_o    : chunk sum is all zeros
module cla_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          ci_i,
    output logic [CW-1:0] sum_o,
    output logic          co_o,
    output logic          cmsb_o,
    output logic          zero_o
);

    logic [CW-1:0] gen;
    logic [CW-1:0] prop;
    logic [CW:0]   carry;
    logic          term;
    logic          run_p;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci
    always_comb begin
        // NOTE: every variable written here gets a value before any branch
        // or loop, so no path can leave it unassigned and infer a latch.
        carry    = '0;
        term     = 1'b0;
        run_p    = 1'b0;
        carry[0] = ci_i;
        for (int i = 0; i < CW; i++) begin
            term  = gen[i];
            run_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term  = term | (run_p & gen[j]);
                run_p = run_p & prop[j];
            end
            carry[i+1] = term | (run_p & ci_i);
        end
    end

    assign sum_o  = prop ^ carry[CW-1:0];
    assign co_o   = carry[CW];
    assign cmsb_o = carry[CW-1];
    assign zero_o = ~|(prop ^ carry[CW-1:0]);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract unit with N/Z/C/V flags.
// Stage k adds chunk k (WIDTH/STAGES bits) using the carry registered by
// stage k-1. Operands and partial results travel with the beat. The whole
// pipe advances together when the output is empty or being consumed.
// WIDTH must be a multiple of STAGES. The chunk width must be at least 4.
//   clk, reset_n         : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, op, ci)
//   out_valid / out_ready: result handshake (s, c, v, n, z)
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage pipeline registers and their next-state values.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             cy_q    [STAGES];
    logic             cmsb_q  [STAGES];
    logic             zero_q  [STAGES];

    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             cy_d    [STAGES];
    logic             cmsb_d  [STAGES];
    logic             zero_d  [STAGES];

    // Values each stage inherits from its predecessor (or from the ports).
    logic [WIDTH-1:0] sum_src  [STAGES];
    logic             zero_src [STAGES];

    // Chunk adder connections.
    logic [CW-1:0] ch_a  [STAGES];
    logic [CW-1:0] ch_b  [STAGES];
    logic          ch_ci [STAGES];
    logic [CW-1:0] ch_s  [STAGES];
    logic          ch_co [STAGES];
    logic          ch_cm [STAGES];
    logic          ch_z  [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // The pipe moves as one unit, so a stall anywhere freezes every stage.
    assign advance  = ~valid_q[LAST] | out_ready;
    assign in_ready = advance;

    assign b_eff = op[0] ? ~b : b;

    always_comb begin
        cin0 = 1'b0;
        case (alu_op_e'(op))
            OP_ADD:         cin0 = 1'b0;
            OP_SUB:         cin0 = 1'b1;
            OP_ADC, OP_SBC: cin0 = ci;
        endcase
    end

    // Stage inputs: stage 0 reads the ports, later stages read the registers
    // of the stage before.
    always_comb begin
        a_d[0]      = a;
        b_d[0]      = b_eff;
        valid_d[0]  = in_valid;
        ch_ci[0]    = cin0;
        sum_src[0]  = '0;
        zero_src[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]      = a_q[k-1];
            b_d[k]      = b_q[k-1];
            valid_d[k]  = valid_q[k-1];
            ch_ci[k]    = cy_q[k-1];
            sum_src[k]  = sum_q[k-1];
            zero_src[k] = zero_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            ch_a[k] = a_d[k][k*CW +: CW];
            ch_b[k] = b_d[k][k*CW +: CW];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_chunk #(.CW(CW)) u_chunk (
            .a_i    (ch_a[k]),
            .b_i    (ch_b[k]),
            .ci_i   (ch_ci[k]),
            .sum_o  (ch_s[k]),
            .co_o   (ch_co[k]),
            .cmsb_o (ch_cm[k]),
            .zero_o (ch_z[k])
        );
    end

    // Merge each chunk result into the partial sum and the running zero flag.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]               = sum_src[k];
            sum_d[k][k*CW +: CW]   = ch_s[k];
            zero_d[k]              = zero_src[k] & ch_z[k];
            cy_d[k]                = ch_co[k];
            cmsb_d[k]              = ch_cm[k];
        end
    end

    // NOTE: the datapath registers are reset along with the valid bits. This
    // makes s and the flags read as zero after reset without extra muxing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                cy_q[k]    <= 1'b0;
                cmsb_q[k]  <= 1'b0;
                zero_q[k]  <= 1'b0;
            end
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, which is what makes this a shift chain.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                cy_q[k]    <= cy_d[k];
                cmsb_q[k]  <= cmsb_d[k];
                zero_q[k]  <= zero_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign s         = sum_q[LAST];
    assign c         = cy_q[LAST];
    assign v         = cy_q[LAST] ^ cmsb_q[LAST];
    assign n         = sum_q[LAST][WIDTH-1];
    assign z         = zero_q[LAST];

endmodule
